// File: rtl/alarm_ctrl.sv
// Alarm sequencer: detects the alarm instant from the timekeeper, runs the
// ring/snooze/stop state machine and drives a gated buzzer tone.
module alarm_ctrl #(
  parameter int unsigned CLK_PER_SEC      = 1000,
  parameter int unsigned RING_TIMEOUT_SEC = 60,
  parameter int unsigned SNOOZE_SEC       = 300,
  parameter int unsigned MAX_SNOOZE       = 3,
  parameter int unsigned TONE_HALF        = 1
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic [17:0] CUR_TIME,
  input  logic [16:0] ALARM_TIME,
  input  logic        ALARM_EN,
  input  logic        SETTING,
  input  logic        BTN_SNOOZE,
  input  logic        BTN_STOP,
  output logic        BUZZER,
  output logic        ALARM_ACTIVE,
  output logic        SNOOZED,
  output logic [1:0]  STATE
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRing   = 2'd1,
    StSnooze = 2'd2
  } state_e;

  localparam int unsigned BeepW = $clog2(CLK_PER_SEC);
  localparam int unsigned ToneW = $clog2(TONE_HALF + 1);
  localparam logic [BeepW-1:0] BeepLast = BeepW'(CLK_PER_SEC - 1);
  localparam logic [BeepW-1:0] BeepHalf = BeepW'(CLK_PER_SEC / 2);
  localparam logic [ToneW-1:0] ToneLast = ToneW'(TONE_HALF - 1);
  localparam logic [15:0]      RingTo   = 16'(RING_TIMEOUT_SEC);
  localparam logic [15:0]      SnzLoad  = 16'(SNOOZE_SEC);
  localparam logic [2:0]       MaxSnz   = 3'(MAX_SNOOZE);

  logic [2:0] snz_sync_q, stop_sync_q;
  logic       snz_pulse_q, stop_pulse_q;
  logic [5:0] prev_sec_q;
  logic       prev_match_q;

  state_e           state_q, state_d;
  logic [15:0]      ring_sec_q, ring_sec_d;
  logic [15:0]      snz_sec_q, snz_sec_d;
  logic [2:0]       snz_cnt_q, snz_cnt_d;
  logic [BeepW-1:0] beep_q, beep_d;
  logic [ToneW-1:0] tone_cnt_q, tone_cnt_d;
  logic             tone_q, tone_d;
  logic             buzzer_q, buzzer_d;
  logic             active_q, snoozed_q;
  logic             restart;

  logic sec_tick, match, fire;
  logic unused_meridian;

  // Meridian is a display attribute only; HOUR is already 0..23.
  assign unused_meridian = CUR_TIME[17];

  assign sec_tick = !SETTING && (CUR_TIME[5:0] != prev_sec_q);
  assign match    = ALARM_EN && !SETTING && (CUR_TIME[16:0] == ALARM_TIME);
  assign fire     = match && !prev_match_q;

  always_comb begin
    state_d    = state_q;
    ring_sec_d = ring_sec_q;
    snz_sec_d  = snz_sec_q;
    snz_cnt_d  = snz_cnt_q;
    restart    = 1'b0;
    if (!ALARM_EN) begin
      state_d   = StIdle;
      snz_cnt_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (fire) begin
            state_d    = StRing;
            ring_sec_d = '0;
            snz_cnt_d  = '0;
            restart    = 1'b1;
          end
        end
        StRing: begin
          if (stop_pulse_q) begin
            state_d = StIdle;
          end else if (snz_pulse_q && (snz_cnt_q < MaxSnz)) begin
            state_d   = StSnooze;
            snz_sec_d = SnzLoad;
            snz_cnt_d = snz_cnt_q + 3'd1;
          end else if (sec_tick) begin
            ring_sec_d = ring_sec_q + 16'd1;
            if (ring_sec_d == RingTo) state_d = StIdle;
          end
        end
        StSnooze: begin
          if (stop_pulse_q) begin
            state_d = StIdle;
          end else if (sec_tick) begin
            snz_sec_d = snz_sec_q - 16'd1;
            if (snz_sec_d == 16'd0) begin
              state_d    = StRing;
              ring_sec_d = '0;
              restart    = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Envelope and tone restart on every entry to ringing so each ring begins with a beep.
  always_comb begin
    beep_d     = beep_q;
    tone_cnt_d = tone_cnt_q;
    tone_d     = tone_q;
    if (restart) begin
      beep_d     = '0;
      tone_cnt_d = '0;
      tone_d     = 1'b0;
    end else if (state_q == StRing) begin
      beep_d = (beep_q == BeepLast) ? '0 : beep_q + BeepW'(1);
      if (tone_cnt_q == ToneLast) begin
        tone_cnt_d = '0;
        tone_d     = ~tone_q;
      end else begin
        tone_cnt_d = tone_cnt_q + ToneW'(1);
      end
    end
    buzzer_d = (state_d == StRing) && (beep_d < BeepHalf) && tone_d;
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      snz_sync_q   <= '0;
      stop_sync_q  <= '0;
      snz_pulse_q  <= 1'b0;
      stop_pulse_q <= 1'b0;
      prev_sec_q   <= '0;
      prev_match_q <= 1'b1;
      state_q      <= StIdle;
      ring_sec_q   <= '0;
      snz_sec_q    <= '0;
      snz_cnt_q    <= '0;
      beep_q       <= '0;
      tone_cnt_q   <= '0;
      tone_q       <= 1'b0;
      buzzer_q     <= 1'b0;
      active_q     <= 1'b0;
      snoozed_q    <= 1'b0;
    end else begin
      snz_sync_q   <= {snz_sync_q[1:0], BTN_SNOOZE};
      stop_sync_q  <= {stop_sync_q[1:0], BTN_STOP};
      snz_pulse_q  <= snz_sync_q[1] & ~snz_sync_q[2];
      stop_pulse_q <= stop_sync_q[1] & ~stop_sync_q[2];
      prev_sec_q   <= CUR_TIME[5:0];
      prev_match_q <= match;
      state_q      <= state_d;
      ring_sec_q   <= ring_sec_d;
      snz_sec_q    <= snz_sec_d;
      snz_cnt_q    <= snz_cnt_d;
      beep_q       <= beep_d;
      tone_cnt_q   <= tone_cnt_d;
      tone_q       <= tone_d;
      buzzer_q     <= buzzer_d;
      active_q     <= (state_d == StRing);
      snoozed_q    <= (state_d == StSnooze);
    end
  end

  assign BUZZER       = buzzer_q;
  assign ALARM_ACTIVE = active_q;
  assign SNOOZED      = snoozed_q;
  assign STATE        = state_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: fixed vector table, directed corner sequences and a
// randomized run checked cycle by cycle against a behavioural model.
module tb_alarm_ctrl;

  localparam int Cps      = 1000;
  localparam int RingTo   = 5;
  localparam int SnzSec   = 3;
  localparam int MaxSnz   = 3;
  localparam int ToneHalf = 1;
  localparam int AlarmTod = 7 * 3600 + 30 * 60;

  localparam logic [15:0] ExpIdle  = 16'h0000;
  localparam logic [15:0] ExpRing0 = 16'h000C;
  localparam logic [15:0] ExpRing1 = 16'h000D;
  localparam logic [15:0] ExpSnz   = 16'h0012;

  logic        clk = 1'b0;
  logic        resetn;
  logic [17:0] cur_time;
  logic [16:0] alarm_time;
  logic        alarm_en, setting, btn_snooze, btn_stop;
  logic        buzzer, alarm_active, snoozed;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alarm_ctrl #(
    .CLK_PER_SEC     (Cps),
    .RING_TIMEOUT_SEC(RingTo),
    .SNOOZE_SEC      (SnzSec),
    .MAX_SNOOZE      (MaxSnz),
    .TONE_HALF       (ToneHalf)
  ) dut (
    .CLK         (clk),
    .RESETN      (resetn),
    .CUR_TIME    (cur_time),
    .ALARM_TIME  (alarm_time),
    .ALARM_EN    (alarm_en),
    .SETTING     (setting),
    .BTN_SNOOZE  (btn_snooze),
    .BTN_STOP    (btn_stop),
    .BUZZER      (buzzer),
    .ALARM_ACTIVE(alarm_active),
    .SNOOZED     (snoozed),
    .STATE       (state)
  );

  // Reference model: state as 0/1/2, seconds elapsed/left, cycles since ring start,
  // and the last four raw button samples (a press acts three edges after sampling).
  int m_state, m_ring, m_snz, m_used, m_k, m_psec;
  bit m_buz, m_pmatch;
  bit hs[4];
  bit hp[4];
  bit mer;
  int tod;
  int hi_on, hi_off;

  typedef struct {
    bit          rst_n;
    bit          en;
    bit          set;
    bit          snz;
    bit          stp;
    logic [17:0] t;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] outs();
    return {11'b0, state, alarm_active, snoozed, buzzer};
  endfunction

  function automatic logic [15:0] pack(input int st, input bit bz);
    return {11'b0, 2'(st), (st == 1), (st == 2), bz};
  endfunction

  function automatic logic [17:0] tm(input bit m, input int h, input int mi, input int s);
    return {m, 5'(h), 6'(mi), 6'(s)};
  endfunction

  task automatic set_tod(input int t);
    tod = t;
    cur_time = tm(mer, t / 3600, (t / 60) % 60, t % 60);
  endtask

  task automatic model_edge();
    bit sp, pp, tk, mt, fr, start;
    int ns;
    if (!resetn) begin
      m_state = 0; m_ring = 0; m_snz = 0; m_used = 0; m_k = 0;
      m_buz = 0; m_psec = 0; m_pmatch = 1;
      for (int i = 0; i < 4; i++) begin
        hs[i] = 0;
        hp[i] = 0;
      end
      return;
    end
    sp    = hs[2] && !hs[3];
    pp    = hp[2] && !hp[3];
    tk    = !setting && (int'(cur_time[5:0]) != m_psec);
    mt    = alarm_en && !setting && (cur_time[16:0] == alarm_time);
    fr    = mt && !m_pmatch;
    ns    = m_state;
    start = 0;
    if (!alarm_en) begin
      ns = 0;
      m_used = 0;
    end else if (m_state == 0) begin
      if (fr) begin
        ns = 1; m_ring = 0; m_used = 0; start = 1;
      end
    end else if (m_state == 1) begin
      if (sp) ns = 0;
      else if (pp && m_used < MaxSnz) begin
        ns = 2; m_snz = SnzSec; m_used++;
      end else if (tk) begin
        m_ring++;
        if (m_ring == RingTo) ns = 0;
      end
    end else begin
      if (sp) ns = 0;
      else if (tk) begin
        m_snz--;
        if (m_snz == 0) begin
          ns = 1; m_ring = 0; start = 1;
        end
      end
    end
    if (start) m_k = 0;
    else if (m_state == 1) m_k++;
    m_state  = ns;
    m_buz    = (ns == 1) && ((m_k % Cps) < Cps / 2) && (((m_k / ToneHalf) % 2) == 1);
    m_psec   = int'(cur_time[5:0]);
    m_pmatch = mt;
    for (int i = 3; i > 0; i--) begin
      hs[i] = hs[i-1];
      hp[i] = hp[i-1];
    end
    hs[0] = btn_stop;
    hp[0] = btn_snooze;
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
    model_edge();
    check("model", outs(), pack(m_state, m_buz));
  endtask

  task automatic press_snooze();
    btn_snooze = 1'b1;
    tick_clk();
    btn_snooze = 1'b0;
    tick_clk();
    tick_clk();
    check("snz_latency", 16'(state), 16'd1);
    tick_clk();
    check("snz_enter", outs(), ExpSnz);
  endtask

  task automatic press_stop();
    btn_stop = 1'b1;
    tick_clk();
    btn_stop = 1'b0;
    tick_clk();
    tick_clk();
    tick_clk();
    check("stop", outs(), ExpIdle);
  endtask

  initial begin
    resetn     = 1'b0;
    alarm_en   = 1'b1;
    setting    = 1'b0;
    btn_snooze = 1'b0;
    btn_stop   = 1'b0;
    mer        = 1'b0;
    alarm_time = {5'd7, 6'd30, 6'd0};
    cur_time   = tm(0, 7, 29, 59);

    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, tm(0, 7, 29, 59), ExpIdle};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, tm(0, 7, 29, 59), ExpIdle};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, tm(0, 7, 30, 0),  ExpRing0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, tm(0, 7, 30, 0),  ExpRing1};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, tm(0, 7, 30, 0),  ExpRing0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, tm(0, 7, 30, 0),  ExpRing1};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, tm(0, 7, 30, 0),  ExpRing0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, tm(0, 7, 30, 0),  ExpRing1};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, tm(0, 7, 30, 0),  ExpIdle};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, tm(0, 7, 30, 0),  ExpIdle};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, tm(0, 7, 30, 0),  ExpIdle};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, tm(0, 7, 30, 0),  ExpIdle};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, tm(0, 7, 30, 1),  ExpIdle};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, tm(1, 7, 30, 0),  ExpRing0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, tm(1, 7, 30, 0),  ExpIdle};

    for (int i = 0; i < 15; i++) begin
      resetn     = vecs[i].rst_n;
      alarm_en   = vecs[i].en;
      setting    = vecs[i].set;
      btn_snooze = vecs[i].snz;
      btn_stop   = vecs[i].stp;
      cur_time   = vecs[i].t;
      tick_clk();
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Fire, full beep envelope, then timeout.
    alarm_en = 1'b1;
    mer = 1'b0;
    set_tod(AlarmTod - 1);
    tick_clk();
    set_tod(AlarmTod);
    tick_clk();
    check("fire", outs(), ExpRing0);
    hi_on  = 0;
    hi_off = 0;
    for (int k = 1; k < Cps; k++) begin
      tick_clk();
      if (buzzer) begin
        if (k < Cps / 2) hi_on++;
        else hi_off++;
      end
    end
    check("beep_on", 16'(hi_on), 16'd250);
    check("beep_off", 16'(hi_off), 16'd0);
    for (int i = 1; i <= RingTo; i++) begin
      set_tod(AlarmTod + i);
      tick_clk();
      if (i == RingTo - 1) check("pre_timeout", 16'(state), 16'd1);
    end
    check("timeout", outs(), ExpIdle);

    // Snooze three times, fourth press ignored, then stop.
    set_tod(AlarmTod);
    tick_clk();
    check("refire", outs(), ExpRing0);
    for (int rep = 0; rep < MaxSnz; rep++) begin
      press_snooze();
      for (int j = 1; j <= SnzSec; j++) begin
        set_tod(tod + 1);
        tick_clk();
        if (j == SnzSec - 1) check("snz_hold", 16'(state), 16'd2);
      end
      check("snz_expire", outs(), ExpRing0);
    end
    btn_snooze = 1'b1;
    tick_clk();
    btn_snooze = 1'b0;
    repeat (4) tick_clk();
    check("snz_limit", 16'(state), 16'd1);
    press_stop();

    // Stop and snooze in the same cycle.
    set_tod(AlarmTod);
    tick_clk();
    check("fire_c", outs(), ExpRing0);
    btn_snooze = 1'b1;
    btn_stop   = 1'b1;
    tick_clk();
    btn_snooze = 1'b0;
    btn_stop   = 1'b0;
    repeat (3) tick_clk();
    check("stop_wins", outs(), ExpIdle);

    // Disarm while snoozing.
    set_tod(AlarmTod + 1);
    tick_clk();
    set_tod(AlarmTod);
    tick_clk();
    check("fire_d", outs(), ExpRing0);
    press_snooze();
    alarm_en = 1'b0;
    tick_clk();
    check("disarm", outs(), ExpIdle);
    set_tod(AlarmTod + 1);
    tick_clk();
    alarm_en = 1'b1;
    tick_clk();
    check("rearm_quiet", outs(), ExpIdle);

    // SETTING freezes the ring timeout but buttons still act.
    set_tod(AlarmTod);
    tick_clk();
    check("fire_f", outs(), ExpRing0);
    setting = 1'b1;
    for (int i = 1; i <= RingTo + 1; i++) begin
      set_tod(AlarmTod + i);
      tick_clk();
    end
    check("setting_freeze", 16'(state), 16'd1);
    press_stop();
    setting = 1'b0;
    tick_clk();

    // Reset mid-ring, time still matching afterwards.
    set_tod(AlarmTod);
    tick_clk();
    check("fire_e", outs(), ExpRing0);
    repeat (3) tick_clk();
    resetn = 1'b0;
    tick_clk();
    check("reset_ring", outs(), ExpIdle);
    resetn = 1'b1;
    repeat (5) tick_clk();
    check("no_refire", outs(), ExpIdle);

    for (int c = 0; c < 30000; c++) begin
      resetn   = ($urandom_range(0, 299) != 0);
      alarm_en = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 39) == 0) setting = ~setting;
      if ($urandom_range(0, 5) == 0) btn_snooze = ~btn_snooze;
      if ($urandom_range(0, 11) == 0) btn_stop = ~btn_stop;
      if ($urandom_range(0, 3) == 0) begin
        mer = 1'($urandom_range(0, 1));
        set_tod(AlarmTod + int'($urandom_range(0, 7)));
      end
      tick_clk();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
- Alarm sequencer downstream of the timekeeper (TIME_CAL).
- Consumes the running time word and the stored alarm time, and detects the alarm instant.
- Runs a ring/snooze/stop state machine from the user buttons and drives a gated buzzer tone.
- Runs on the same 1 kHz system clock as the timekeeper (1000 CLK per second).

Parameters:
- CLK_PER_SEC, 1000: CLK cycles per second; sets the beep envelope period.
- RING_TIMEOUT_SEC, 60: seconds of ringing before automatic stop.
- SNOOZE_SEC, 300: snooze duration in seconds.
- MAX_SNOOZE, 3: number of snoozes allowed per alarm event.
- TONE_HALF, 1: CLK cycles per buzzer half-period (default gives 500 Hz).

Ports:
- CLK  in  1  system clock
- RESETN  in  1  synchronous, active-low reset
- CUR_TIME  in  18  {MERIDIAN, HOUR[4:0], MIN[5:0], SEC[5:0]} from the timekeeper
- ALARM_TIME  in  17  {HOUR, MIN, SEC} stored alarm time
- ALARM_EN  in  1  alarm armed (level)
- SETTING  in  1  timekeeper being edited; suppresses matching and second ticks
- BTN_SNOOZE  in  1  raw snooze button, asynchronous level
- BTN_STOP  in  1  raw stop button, asynchronous level
- BUZZER  out  1  tone output
- ALARM_ACTIVE  out  1  high in RINGING
- SNOOZED  out  1  high in SNOOZE
- STATE  out  2  0=IDLE, 1=RINGING, 2=SNOOZE

Behaviour:
- Reset: RESETN sampled low at a CLK edge forces:
  - outputs: BUZZER=0, ALARM_ACTIVE=0, SNOOZED=0, STATE=IDLE.
  - counters: all zero; snooze count 0.
  - button sync flops: 0.
  - prev_sec=0; prev_match=1, so a reset at the alarm instant never fires.
  - Reset mid-ring or mid-snooze aborts immediately with no residual buzzer.
- Buttons:
  - 2-flop synchroniser, then a rising-edge register, giving a 1-cycle pulse per press.
  - A press first sampled high at edge N acts on STATE at edge N+3.
  - A held button produces only one pulse.
- Second tick: sec_tick=1 for one cycle when CUR_TIME[5:0] != prev_sec and SETTING=0. prev_sec updates every cycle.
- Match:
  - match = ALARM_EN & !SETTING & (CUR_TIME[16:0] == ALARM_TIME). MERIDIAN is ignored; HOUR is 0..23.
  - fire = match & !prev_match; prev_match updates every cycle. fire occurs once per alarm instant.
- FSM, evaluated in this priority order:
  - ALARM_EN=0 in any state -> IDLE (same cycle), snooze count cleared.
  - IDLE: fire -> RINGING; ring_sec cleared, snooze count cleared, beep counters cleared.
  - RINGING, stop pulse -> IDLE. Stop wins over a simultaneous snooze pulse.
  - RINGING, snooze pulse with count < MAX_SNOOZE -> SNOOZE; snz_sec loaded with SNOOZE_SEC, count+1. With count == MAX_SNOOZE the pulse is ignored.
  - RINGING, sec_tick: ring_sec+1. When ring_sec reaches RING_TIMEOUT_SEC -> IDLE.
  - SNOOZE, stop pulse -> IDLE.
  - SNOOZE, sec_tick: snz_sec-1. The tick that reaches 0 -> RINGING, with ring_sec and beep counters cleared.
  - fire in RINGING or SNOOZE: ignored.
- Counter widths: ring_sec and snz_sec are 16 bits; snooze count is 3 bits.
- Buzzer:
  - beep_cnt runs 0..CLK_PER_SEC-1, then wraps.
  - tone toggles every TONE_HALF cycles.
  - BUZZER = RINGING & (beep_cnt < CLK_PER_SEC/2) & tone, registered.
  - Result: 0.5 s beep, 0.5 s silence. BUZZER=0 in the cycle after leaving RINGING.
- ALARM_ACTIVE, SNOOZED and STATE are registered decodes of state, with no glitches.
- SETTING=1 in RINGING or SNOOZE: timeouts freeze (no ticks) and the state is held. Buttons still act.

Test Plan:
- Fire: ALARM_TIME=07:30:00, ALARM_EN=1, CUR_TIME stepped 07:29:59 -> 07:30:00 -> STATE=1 at the next edge; BUZZER toggles every cycle for 500 cycles, then is 0 for 500.
- Timeout: RING_TIMEOUT_SEC=5, no buttons, 5 second ticks -> STATE=0, BUZZER=0; holding 07:30:00 does not refire.
- Snooze: SNOOZE_SEC=3, press snooze in RINGING -> STATE=2 three cycles later; after 3 ticks STATE=1. A 4th snooze (MAX_SNOOZE=3) is ignored.
- Simultaneous: stop and snooze pulse in the same cycle during RINGING -> STATE=0.
- Disarm/setting: ALARM_EN dropped in SNOOZE -> IDLE next edge. SETTING=1 while CUR_TIME equals the alarm -> no fire.
- Reset: RESETN low for 1 cycle during RINGING -> all outputs 0 next edge; no refire while the time still matches.
